// File: rtl/touch_pkg.sv
// Shared types and constants for the touch-zone detector: zone FSM states
// and the power-on bounds of zone 0.
package touch_pkg;

  localparam int MAX_ZONES = 8;

  localparam int Z0_X1 = 181;
  localparam int Z0_X2 = 329;
  localparam int Z0_Y1 = 121;
  localparam int Z0_Y2 = 219;

  typedef enum logic [1:0] {
    ST_REL  = 2'd0,
    ST_ARM  = 2'd1,
    ST_HELD = 2'd2,
    ST_DIS  = 2'd3
  } zone_state_t;

endpackage

// File: rtl/touch_zone_fsm.sv
// Per-zone debounce FSM: DEB consecutive hits confirm a press and DEB
// consecutive misses confirm a release.
//
//   state | meaning
//   REL   | released, waiting for a first hit
//   ARM   | counting consecutive hits toward press confirm
//   HELD  | pressed and stable
//   DIS   | pressed, counting consecutive misses toward release confirm
module touch_zone_fsm
  import touch_pkg::*;
#(
  parameter int DEB = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic i_sample,
  input  logic i_hit,
  input  logic i_clr,
  output logic o_held,
  output logic o_held_nxt,
  output logic o_press,
  output logic o_release
);

  localparam int CW = $clog2(DEB + 1);
  localparam logic [CW-1:0] DEB_C = CW'(DEB);

  zone_state_t r_state;
  zone_state_t w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic r_press;
  logic r_release;
  logic w_press_nxt;
  logic w_release_nxt;

  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_REL;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  // A bounds rewrite outranks any sample taken on the same edge.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    if (i_clr) begin
      w_state_nxt   = ST_REL;
      w_cnt_nxt     = '0;
      w_release_nxt = (r_state == ST_HELD) || (r_state == ST_DIS);
    end else if (i_sample) begin
      case (r_state)
        ST_REL: begin
          if (i_hit) begin
            if (DEB == 1) begin
              w_state_nxt = ST_HELD;
              w_cnt_nxt   = '0;
              w_press_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_ARM;
              w_cnt_nxt   = CW'(1);
            end
          end
        end
        ST_ARM: begin
          if (!i_hit) begin
            w_state_nxt = ST_REL;
            w_cnt_nxt   = '0;
          end else if (w_cnt_inc == DEB_C) begin
            w_state_nxt = ST_HELD;
            w_cnt_nxt   = '0;
            w_press_nxt = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        ST_HELD: begin
          if (!i_hit) begin
            if (DEB == 1) begin
              w_state_nxt   = ST_REL;
              w_cnt_nxt     = '0;
              w_release_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_DIS;
              w_cnt_nxt   = CW'(1);
            end
          end
        end
        ST_DIS: begin
          if (i_hit) begin
            w_state_nxt = ST_HELD;
            w_cnt_nxt   = '0;
          end else if (w_cnt_inc == DEB_C) begin
            w_state_nxt   = ST_REL;
            w_cnt_nxt     = '0;
            w_release_nxt = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: begin
          w_state_nxt = ST_REL;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    o_held     = (r_state == ST_HELD) || (r_state == ST_DIS);
    o_held_nxt = (w_state_nxt == ST_HELD) || (w_state_nxt == ST_DIS);
    o_press    = r_press;
    o_release  = r_release;
  end

endmodule

// File: rtl/touch_zones.sv
// Rectangular touch-zone detector: per-zone bounds registers, hit test on
// the sampled touch coordinate, debounce FSMs and a lowest-index encoder.
module touch_zones
  import touch_pkg::*;
#(
  parameter int NZ    = 4,
  parameter int XW    = 10,
  parameter int YW    = 9,
  parameter int DEB   = 3,
  parameter int PHASE = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [1:0]    clcount,
  input  logic [XW-1:0] tor_x,
  input  logic [YW-1:0] tor_y,
  input  logic          cfg_we,
  input  logic [2:0]    cfg_idx,
  input  logic [XW-1:0] cfg_x1,
  input  logic [XW-1:0] cfg_x2,
  input  logic [YW-1:0] cfg_y1,
  input  logic [YW-1:0] cfg_y2,
  output logic [NZ-1:0] zone_held,
  output logic [NZ-1:0] zone_press,
  output logic [NZ-1:0] zone_release,
  output logic          active_valid,
  output logic [2:0]    active_idx
);

  logic [XW-1:0] r_x1 [NZ];
  logic [XW-1:0] r_x2 [NZ];
  logic [YW-1:0] r_y1 [NZ];
  logic [YW-1:0] r_y2 [NZ];

  logic          w_sample;
  logic [NZ-1:0] w_wr;
  logic [NZ-1:0] w_hit;
  logic [NZ-1:0] w_held;
  logic [NZ-1:0] w_held_nxt;
  logic [NZ-1:0] w_press;
  logic [NZ-1:0] w_release;
  logic          w_act_valid;
  logic [2:0]    w_act_idx;
  logic          r_act_valid;
  logic [2:0]    r_act_idx;

  assign w_sample = enable && (clcount == 2'(PHASE));

  // Unused zones reset to x1 > x2 so they can never hit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NZ; i++) begin
        r_x1[i] <= (i == 0) ? XW'(Z0_X1) : '1;
        r_x2[i] <= (i == 0) ? XW'(Z0_X2) : '0;
        r_y1[i] <= (i == 0) ? YW'(Z0_Y1) : '1;
        r_y2[i] <= (i == 0) ? YW'(Z0_Y2) : '0;
      end
    end else begin
      for (int i = 0; i < NZ; i++) begin
        if (w_wr[i]) begin
          r_x1[i] <= cfg_x1;
          r_x2[i] <= cfg_x2;
          r_y1[i] <= cfg_y1;
          r_y2[i] <= cfg_y2;
        end
      end
    end
  end

  for (genvar g = 0; g < NZ; g++) begin : g_zone
    assign w_wr[g]  = cfg_we && (cfg_idx == 3'(g));
    assign w_hit[g] = (tor_x >= r_x1[g]) && (tor_x <= r_x2[g]) &&
                      (tor_y >= r_y1[g]) && (tor_y <= r_y2[g]);

    touch_zone_fsm #(.DEB(DEB)) u_fsm (
      .clk        (clk),
      .reset      (reset),
      .i_sample   (w_sample),
      .i_hit      (w_hit[g]),
      .i_clr      (w_wr[g]),
      .o_held     (w_held[g]),
      .o_held_nxt (w_held_nxt[g]),
      .o_press    (w_press[g]),
      .o_release  (w_release[g])
    );
  end

  // Encoded from next-state held bits so it lines up with zone_held.
  always_comb begin
    w_act_valid = |w_held_nxt;
    w_act_idx   = '0;
    for (int i = NZ - 1; i >= 0; i--) begin
      if (w_held_nxt[i]) w_act_idx = 3'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_act_valid <= 1'b0;
      r_act_idx   <= '0;
    end else begin
      r_act_valid <= w_act_valid;
      r_act_idx   <= w_act_idx;
    end
  end

  assign zone_held    = w_held;
  assign zone_press   = w_press;
  assign zone_release = w_release;
  assign active_valid = r_act_valid;
  assign active_idx   = r_act_idx;

endmodule

// File: tb/tb_touch_zones.sv
// Scoreboard bench for touch_zones: a level-plus-streak reference model
// pushes the expected outputs per cycle; a monitor pops and compares.
module tb_touch_zones;

  localparam int NZ    = 4;
  localparam int XW    = 10;
  localparam int YW    = 9;
  localparam int DEB   = 3;
  localparam int PHASE = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [1:0]    clcount;
  logic [XW-1:0] tor_x;
  logic [YW-1:0] tor_y;
  logic          cfg_we;
  logic [2:0]    cfg_idx;
  logic [XW-1:0] cfg_x1, cfg_x2;
  logic [YW-1:0] cfg_y1, cfg_y2;
  logic [NZ-1:0] zone_held, zone_press, zone_release;
  logic          active_valid;
  logic [2:0]    active_idx;

  always #5 clk = ~clk;

  touch_zones #(.NZ(NZ), .XW(XW), .YW(YW), .DEB(DEB), .PHASE(PHASE)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .clcount      (clcount),
    .tor_x        (tor_x),
    .tor_y        (tor_y),
    .cfg_we       (cfg_we),
    .cfg_idx      (cfg_idx),
    .cfg_x1       (cfg_x1),
    .cfg_x2       (cfg_x2),
    .cfg_y1       (cfg_y1),
    .cfg_y2       (cfg_y2),
    .zone_held    (zone_held),
    .zone_press   (zone_press),
    .zone_release (zone_release),
    .active_valid (active_valid),
    .active_idx   (active_idx)
  );

  typedef struct packed {
    logic [NZ-1:0] held;
    logic [NZ-1:0] press;
    logic [NZ-1:0] rel;
    logic          av;
    logic [2:0]    idx;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  bit started = 0;
  bit done = 0;

  // Reference model: confirmed level plus count of consecutive samples that
  // disagree with it; the level flips when that count reaches DEB.
  bit m_held [NZ];
  int m_str  [NZ];
  int mx1 [NZ];
  int mx2 [NZ];
  int my1 [NZ];
  int my2 [NZ];

  task automatic model_reset();
    for (int i = 0; i < NZ; i++) begin
      m_held[i] = 0;
      m_str[i]  = 0;
      mx1[i] = (i == 0) ? 181 : 1023;
      mx2[i] = (i == 0) ? 329 : 0;
      my1[i] = (i == 0) ? 121 : 511;
      my2[i] = (i == 0) ? 219 : 0;
    end
  endtask

  task automatic check(string nm, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic cyc(bit rst, bit en, int clc, int x, int y,
                     bit we = 0, int idx = 0,
                     int x1 = 0, int x2 = 0, int y1 = 0, int y2 = 0);
    exp_t e;
    bit smp;
    bit hit;
    @(negedge clk);
    reset   = rst;
    enable  = en;
    clcount = 2'(clc);
    tor_x   = XW'(x);
    tor_y   = YW'(y);
    cfg_we  = we;
    cfg_idx = 3'(idx);
    cfg_x1  = XW'(x1);
    cfg_x2  = XW'(x2);
    cfg_y1  = YW'(y1);
    cfg_y2  = YW'(y2);
    e = '0;
    if (!rst) begin
      model_reset();
    end else begin
      smp = en && (clc == PHASE);
      for (int i = 0; i < NZ; i++) begin
        hit = (x >= mx1[i]) && (x <= mx2[i]) && (y >= my1[i]) && (y <= my2[i]);
        if (we && idx == i) begin
          e.rel[i]  = m_held[i];
          m_held[i] = 0;
          m_str[i]  = 0;
        end else if (smp) begin
          if (hit != m_held[i]) begin
            m_str[i]++;
            if (m_str[i] == DEB) begin
              m_held[i] = hit;
              m_str[i]  = 0;
              if (hit) e.press[i] = 1'b1;
              else     e.rel[i]   = 1'b1;
            end
          end else begin
            m_str[i] = 0;
          end
        end
      end
      if (we && idx < NZ) begin
        mx1[idx] = x1; mx2[idx] = x2; my1[idx] = y1; my2[idx] = y2;
      end
    end
    for (int i = NZ - 1; i >= 0; i--) begin
      e.held[i] = m_held[i];
      if (m_held[i]) begin
        e.av  = 1'b1;
        e.idx = 3'(i);
      end
    end
    q.push_back(e);
    started = 1;
  endtask

  task automatic sample_pt(int x, int y);
    cyc(1, 1, 2, x, y);
    cyc(1, 1, PHASE, x, y);
  endtask

  task automatic cfg_wr(int idx, int x1, int x2, int y1, int y2);
    cyc(1, 1, 0, 0, 0, 1, idx, x1, x2, y1, y2);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("zone_held",    int'(zone_held),    int'(e.held));
        check("zone_press",   int'(zone_press),   int'(e.press));
        check("zone_release", int'(zone_release), int'(e.rel));
        check("active_valid", int'(active_valid), int'(e.av));
        check("active_idx",   int'(active_idx),   int'(e.idx));
      end else if (started && !done) begin
        total++;
        bad++;
        $display("FAIL sb_empty actual=0 required=1 at %0t", $time);
      end
    end
  end

  initial begin : driver
    int x, y, j, x1, x2, y1, y2;
    reset = 0; enable = 0; clcount = 0; tor_x = 0; tor_y = 0;
    cfg_we = 0; cfg_idx = 0; cfg_x1 = 0; cfg_x2 = 0; cfg_y1 = 0; cfg_y2 = 0;
    model_reset();
    repeat (3) cyc(0, 0, 0, 0, 0);

    // Basic press, then release by misses
    repeat (3) sample_pt(200, 150);
    repeat (3) sample_pt(500, 400);
    // Interrupted press confirms only on the sixth sample
    sample_pt(200, 150); sample_pt(200, 150); sample_pt(500, 400);
    repeat (3) sample_pt(200, 150);
    repeat (3) sample_pt(0, 0);
    // Inclusive corners and points just outside
    repeat (3) sample_pt(181, 121);
    repeat (3) sample_pt(0, 0);
    repeat (3) sample_pt(329, 219);
    repeat (3) sample_pt(0, 0);
    repeat (5) sample_pt(180, 150);
    repeat (5) sample_pt(330, 150);
    // Rewrite of a held zone forces release
    repeat (3) sample_pt(200, 150);
    cfg_wr(0, 0, 10, 0, 10);
    cyc(1, 1, 0, 0, 0);
    // Overlapping zones press together
    cfg_wr(1, 100, 300, 100, 200);
    cfg_wr(2, 150, 400, 50, 250);
    cfg_wr(5, 0, 1023, 0, 511);
    repeat (3) sample_pt(200, 150);
    // Frozen while disabled
    for (int k = 0; k < 10; k++) cyc(1, 0, k % 4, 900, 500);
    // Rewrite of zone 1 on a sampling edge with a miss elsewhere
    cyc(1, 1, PHASE, 350, 240, 1, 1, 0, 50, 0, 50);
    repeat (3) sample_pt(350, 240);
    // Reset mid-hold
    repeat (3) sample_pt(200, 150);
    cyc(0, 1, PHASE, 200, 150);
    repeat (2) cyc(1, 1, 0, 0, 0);

    // Randomized traffic
    x = 200; y = 150;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        j = $urandom_range(0, NZ - 1);
        if ($urandom_range(0, 1) == 0 && mx1[j] <= mx2[j] && my1[j] <= my2[j]) begin
          x = $urandom_range(mx1[j], mx2[j]);
          y = $urandom_range(my1[j], my2[j]);
        end else begin
          x = $urandom_range(0, 1023);
          y = $urandom_range(0, 511);
        end
      end
      if ($urandom_range(0, 299) == 0) begin
        cyc(0, 1, $urandom_range(0, 3), x, y);
      end else if ($urandom_range(0, 39) == 0) begin
        x1 = $urandom_range(0, 600);
        x2 = x1 + $urandom_range(0, 400);
        y1 = $urandom_range(0, 300);
        y2 = y1 + $urandom_range(0, 200);
        if ($urandom_range(0, 4) == 0) x2 = $urandom_range(0, 1023);
        cyc(1, $urandom_range(0, 9) != 0, $urandom_range(0, 3), x, y,
            1, $urandom_range(0, 7), x1, x2, y1, y2);
      end else begin
        cyc(1, $urandom_range(0, 9) != 0, $urandom_range(0, 3), x, y);
      end
    end

    done = 1;
    repeat (3) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
